multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore FSM that sequences a multicycle MIPS datapath built from the existing program_counter, instruction_memory, alu, mux2to1, mux4to1 and sign_extender blocks, sharing one ALU and one memory port across cycles.
- Decodes opcode/funct and drives every mux select, write enable and the 3-bit ALU control code.
- Stalls on a memory-ready handshake so slow memories can be used.

Parameters:
- USE_MEM_READY, 1, 1 = wait for mem_ready in memory states; 0 = treat mem_ready as always 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completed the current access this cycle.
- pc_en  out  1  PC load: pc_write | (branch & zero).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_req  out  1  memory access request.
- mem_write  out  1  store request.
- ir_write  out  1  load instruction register.
- reg_dst  out  1  write register select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  writeback select: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- pc_src  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_control  out  3  ALU operation code.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode or funct.
- state_dbg  out  4  current state encoding.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high: on a rising edge with reset=1, state <= FETCH.
- While reset=1, all of the following are forced to 0 combinationally: pc_en, mem_req, mem_write, ir_write, reg_write, illegal_op.
- Outputs are a pure function of state (Moore), except:
  - write enables gated by mem_ready;
  - alu_control and illegal_op, which also depend on funct.
- Defaults are 0 and alu_control = 010, unless a state says otherwise.
- States, encoded 0..11:
  - FETCH(0): mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, pc_src=00. ir_write and pc_write asserted only when mem_ready. Advance to DECODE on mem_ready, else hold.
  - DECODE(1): alu_src_a=0, alu_src_b=11 (precomputes branch target into ALUOut). Next state by opcode:
    - 100011 lw / 101011 sw -> MEMADR
    - 000000 -> EXEC
    - 000100 beq -> BRANCH
    - 001000 addi -> ADDIEX
    - 000010 j -> JUMP
    - other -> FETCH, with illegal_op=1.
  - MEMADR(2): alu_src_a=1, alu_src_b=10. Next is MEMRD for lw, MEMWR for sw.
  - MEMRD(3): mem_req=1, iord=1. Go to MEMWB on mem_ready, else hold.
  - MEMWB(4): reg_write=1, reg_dst=0, mem_to_reg=1. Next is FETCH.
  - MEMWR(5): mem_req=1, iord=1, mem_write=1. Go to FETCH on mem_ready, else hold.
  - EXEC(6): alu_src_a=1, alu_src_b=00, alu_control from funct:
    - 100000 -> 010
    - 100010 -> 110
    - 100100 -> 000
    - 100101 -> 001
    - 101010 -> 111
    - other -> 010 with illegal_op=1; the instruction still completes.
    - Next is ALUWB.
  - ALUWB(7): reg_write=1, reg_dst=1, mem_to_reg=0. Next is FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_control=110, branch=1, pc_src=01. Next is FETCH.
  - ADDIEX(9): alu_src_a=1, alu_src_b=10, alu_control=010. Next is ADDIWB.
  - ADDIWB(10): reg_write=1, reg_dst=0, mem_to_reg=0. Next is FETCH.
  - JUMP(11): pc_src=10, pc_write=1. Next is FETCH.
- Encodings 12–15 are unreachable. If ever entered, the next state is FETCH and all enables are 0.
- Latency with mem_ready held at 1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3. Each cycle of mem_ready=0 in a memory state adds one cycle.
- Handshake: mem_req is held stable until the cycle in which mem_ready=1. A mem_ready outside a memory state is ignored.
- Simultaneous events: reset has priority over any transition, including mid-instruction and mid-stall. No partial write completes in the reset cycle.
- illegal_op is asserted for exactly the one cycle spent in DECODE (bad opcode) or EXEC (bad funct).

Decomposition:
- Shared package holds:
  - state encodings;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - funct constants;
  - ALU codes ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SUB=110, ALU_SLT=111;
  - ALU-B select constants.
- One natural sub-module, alu_decoder: combinational mapping of (alu_op[1:0], funct) to (alu_control, illegal_funct), with alu_op 00 = add, 01 = sub, 10 = funct-driven.

Test Plan:
- Reset, then opcode=100011, mem_ready=1 -> state sequence 0,1,2,3,4,0; reg_write=1 only in MEMWB with mem_to_reg=1; exactly one pc_en pulse.
- R-type with funct=101010 -> EXEC drives alu_control=111, alu_src_b=00; ALUWB has reg_dst=1; 4 cycles total.
- beq with zero=1 in BRANCH -> pc_en=1, pc_src=01. Repeat with zero=0 -> pc_en=0 in BRANCH; back to FETCH either way.
- sw with mem_ready low for 3 cycles in MEMWR -> mem_req and mem_write held for 4 cycles; total latency 7 cycles; no reg_write.
- opcode=111111 -> illegal_op pulses for one cycle in DECODE, next state FETCH, no writes. funct=000000 -> illegal_op in EXEC, alu_control=010.
- reset asserted in MEMRD while mem_ready=0 -> next state FETCH; pc_en, reg_write, mem_req and ir_write are 0 in the reset cycle.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_pkg
//  Description : Shared state encodings, opcode/funct values, ALU codes and
//                mux select values for the multicycle MIPS control unit.
//  Revision    : 1.0  initial release
// ============================================================================
package multicycle_control_pkg;

  // Controller states; the numeric values are visible on state_dbg
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct field values (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B-operand select
  localparam logic [1:0] ALUB_REG     = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Coarse ALU operation handed from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage : multicycle_control_pkg
`default_nettype wire

// File: rtl/multicycle_control_alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_alu_decoder
//  Description : Maps the FSM's coarse ALU operation plus the funct field to
//                the 3-bit ALU control code; flags unsupported funct values.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control_alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_control,
  output logic       o_illegal_funct
);

  // Funct only matters when the FSM asks for an R-type operation
  always_comb begin
    o_alu_control   = ALU_ADD;
    o_illegal_funct = 1'b0;
    case (i_alu_op)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  o_alu_control = ALU_ADD;
          FN_SUB:  o_alu_control = ALU_SUB;
          FN_AND:  o_alu_control = ALU_AND;
          FN_OR:   o_alu_control = ALU_OR;
          FN_SLT:  o_alu_control = ALU_SLT;
          default: begin
            // Unknown funct still executes as an add so the instruction completes
            o_alu_control   = ALU_ADD;
            o_illegal_funct = 1'b1;
          end
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule : multicycle_control_alu_decoder
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Moore FSM sequencing a multicycle MIPS datapath with a shared
//                ALU and a single memory port with a ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_req,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_e     state_q;
  state_e     state_d;

  logic       w_ready;
  logic       w_pc_write;
  logic       w_branch;
  logic       w_mem_req;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_bad_opcode;
  logic       w_in_exec;
  logic [1:0] w_alu_op;
  logic       w_illegal_funct;

  // With the handshake disabled every access completes in one cycle
  assign w_ready = USE_MEM_READY ? mem_ready : 1'b1;

  // State register; reset overrides any pending transition
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore outputs; memory-gated enables use w_ready
  always_comb begin
    state_d      = S_FETCH;
    w_pc_write   = 1'b0;
    w_branch     = 1'b0;
    w_mem_req    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_bad_opcode = 1'b0;
    w_in_exec    = 1'b0;
    w_alu_op     = ALUOP_ADD;
    iord         = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = ALUB_REG;
    pc_src       = PCSRC_ALU;
    case (state_q)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        alu_src_b  = ALUB_FOUR;
        w_ir_write = w_ready;
        w_pc_write = w_ready;
        state_d    = w_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut here
        alu_src_b = ALUB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d      = S_FETCH;
            w_bad_opcode = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        iord      = 1'b1;
        state_d   = w_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_reg_write = 1'b1;
        mem_to_reg  = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWR: begin
        // Request and write strobe stay up for the whole stall
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        iord        = 1'b1;
        state_d     = w_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        w_alu_op  = ALUOP_FUNCT;
        w_in_exec = 1'b1;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        reg_dst     = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        w_alu_op  = ALUOP_SUB;
        w_branch  = 1'b1;
        pc_src    = PCSRC_ALUOUT;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = PCSRC_JUMP;
        w_pc_write = 1'b1;
        state_d    = S_FETCH;
      end
      default: begin
        // Unused encodings recover to FETCH with everything idle
        state_d = S_FETCH;
      end
    endcase
  end

  multicycle_control_alu_decoder u_alu_decoder (
    .i_alu_op        (w_alu_op),
    .i_funct         (funct),
    .o_alu_control   (alu_control),
    .o_illegal_funct (w_illegal_funct)
  );

  // Reset squashes every enable so nothing half-completes in the reset cycle
  assign pc_en      = ~reset & (w_pc_write | (w_branch & zero));
  assign mem_req    = ~reset & w_mem_req;
  assign mem_write  = ~reset & w_mem_write;
  assign ir_write   = ~reset & w_ir_write;
  assign reg_write  = ~reset & w_reg_write;
  assign illegal_op = ~reset & (w_bad_opcode | (w_in_exec & w_illegal_funct));
  assign state_dbg  = state_q;

endmodule : multicycle_control
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Directed scoreboard bench for multicycle_control. The driver
//                queues the hand-derived expected outputs of every cycle; a
//                monitor on the falling edge pops and compares them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en;
    logic       iord;
    logic       mem_req;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_ctl;
    logic       ill;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, iord, mem_req, mem_write, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] state_dbg;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  multicycle_control #(.USE_MEM_READY(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_req(mem_req),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_control(alu_control),
    .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Expected outputs for one cycle, written down state by state
  function automatic exp_t mk(input logic [3:0] st, input logic rdy, input logic z,
                              input logic rst, input logic [2:0] ctl, input logic ill);
    exp_t e;
    e = '0;
    e.st = st;
    e.alu_ctl = 3'b010;
    case (st)
      4'd0:  begin e.mem_req = 1'b1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_en = rdy; end
      4'd1:  begin e.alu_src_b = 2'b11; e.ill = ill; end
      4'd2:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      4'd3:  begin e.mem_req = 1'b1; e.iord = 1'b1; end
      4'd4:  begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
      4'd5:  begin e.mem_req = 1'b1; e.iord = 1'b1; e.mem_write = 1'b1; end
      4'd6:  begin e.alu_src_a = 1'b1; e.alu_ctl = ctl; e.ill = ill; end
      4'd7:  begin e.reg_write = 1'b1; e.reg_dst = 1'b1; end
      4'd8:  begin e.alu_src_a = 1'b1; e.alu_ctl = 3'b110; e.pc_src = 2'b01; e.pc_en = z; end
      4'd9:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      4'd10: begin e.reg_write = 1'b1; end
      4'd11: begin e.pc_src = 2'b10; e.pc_en = 1'b1; end
      default: ;
    endcase
    if (rst) begin
      e.pc_en = 1'b0; e.mem_req = 1'b0; e.mem_write = 1'b0;
      e.ir_write = 1'b0; e.reg_write = 1'b0; e.ill = 1'b0;
    end
    return e;
  endfunction

  // One cycle of stimulus plus its expected response
  task automatic s(input logic [3:0] st, input logic [5:0] op, input logic [5:0] fn,
                   input logic rdy, input logic z, input logic rst,
                   input logic [2:0] ctl, input logic ill, input string nm);
    @(posedge clk);
    #1;
    opcode = op; funct = fn; mem_ready = rdy; zero = z; reset = rst;
    exp_q.push_back(mk(st, rdy, z, rst, ctl, ill));
    name_q.push_back(nm);
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [2:0] ctl, input logic ill,
                       input string nm);
    s(4'd0, RT, fn, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, {nm, "_fetch"});
    s(4'd1, RT, fn, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, {nm, "_decode"});
    s(4'd6, RT, fn, 1'b1, 1'b0, 1'b0, ctl,    ill,  {nm, "_exec"});
    s(4'd7, RT, fn, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, {nm, "_aluwb"});
  endtask

  // Monitor: compare the DUT against the oldest queued expectation
  exp_t  m_exp;
  exp_t  m_act;
  string m_nm;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_exp = exp_q.pop_front();
      m_nm  = name_q.pop_front();
      m_act = {state_dbg, pc_en, iord, mem_req, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src, alu_control,
               illegal_op};
      n_cmp++;
      if (m_act !== m_exp) begin
        n_fail++;
        $display("FAIL %s: got st=%0d {pc_en iord req wr irw dst m2r rw a} %b b=%b pcs=%b alu=%b ill=%b ; want st=%0d %b b=%b pcs=%b alu=%b ill=%b",
                 m_nm, m_act.st,
                 {m_act.pc_en, m_act.iord, m_act.mem_req, m_act.mem_write, m_act.ir_write,
                  m_act.reg_dst, m_act.mem_to_reg, m_act.reg_write, m_act.alu_src_a},
                 m_act.alu_src_b, m_act.pc_src, m_act.alu_ctl, m_act.ill,
                 m_exp.st,
                 {m_exp.pc_en, m_exp.iord, m_exp.mem_req, m_exp.mem_write, m_exp.ir_write,
                  m_exp.reg_dst, m_exp.mem_to_reg, m_exp.reg_write, m_exp.alu_src_a},
                 m_exp.alu_src_b, m_exp.pc_src, m_exp.alu_ctl, m_exp.ill);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held: FETCH with all enables squashed
    s(4'd0, LW, 6'd0, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0, "reset_state");

    // lw, no stalls: 0,1,2,3,4 then FETCH
    s(4'd0, LW, 6'd0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, "lw_fetch");
    s(4'd1, LW, 6'd0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, "lw_decode");
    s(4'd2, LW, 6'd0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, "lw_memadr");
    s(4'd3, LW, 6'd0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, "lw_memrd");
    s(4'd4, LW, 6'd0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, "lw_memwb");

    // R-type decodes, including slt and an unsupported funct
    rtype(6'b101010, 3'b111, 1'b0, "slt");
    rtype(6'b100000, 3'b010, 1'b0, "add");
    rtype(6'b100010, 3'b110, 1'b0, "sub");
    rtype(6'b100100, 3'b000, 1'b0, "and");
    rtype(6'b100101, 3'b001, 1'b0, "or");
    rtype(6'b000000, 3'b010, 1'b1, "badfunct");

    // beq taken (zero held high everywhere; only BRANCH may use it)
    s(4'd0, BEQ, 6'd0, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0, "beqT_fetch");
    s(4'd1, BEQ, 6'd0, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0, "beqT_decode");
    s(4'd8, BEQ, 6'd0, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0, "beqT_branch");
    // beq not taken
    s(4'd0, BEQ, 6'd0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, "beqN_fetch");
    s(4'd1, BEQ, 6'd0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, "beqN_decode");
    s(4'd8, BEQ, 6'd0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, "beqN_branch");

    // sw with three stall cycles in MEMWR; stray mem_ready=0 in DECODE ignored
    s(4'd0, SW, 6'd0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, "sw_fetch");
    s(4'd1, SW, 6'd0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, "sw_decode");
    s(4'd2, SW, 6'd0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, "sw_memadr");
    s(4'd5, SW, 6'd0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, "sw_stall1");
    s(4'd5, SW, 6'd0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, "sw_stall2");
    s(4'd5, SW, 6'd0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, "sw_stall3");
    s(4'd5, SW, 6'd0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, "sw_memwr");

    // addi with a one-cycle fetch stall
    s(4'd0, ADDI, 6'd0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, "addi_fstall");
    s(4'd0, ADDI, 6'd0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, "addi_fetch");
    s(4'd1, ADDI, 6'd0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, "addi_decode");
    s(4'd9, ADDI, 6'd0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, "addi_ex");
    s(4'd10, ADDI, 6'd0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, "addi_wb");

    // j
    s(4'd0, JMP, 6'd0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, "j_fetch");
    s(4'd1, JMP, 6'd0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, "j_decode");
    s(4'd11, JMP, 6'd0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, "j_jump");

    // Illegal opcode: one-cycle pulse in DECODE, straight back to FETCH
    s(4'd0, BAD, 6'd0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, "badop_fetch");
    s(4'd1, BAD, 6'd0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, "badop_decode");

    // Reset mid-stall in MEMRD
    s(4'd0, LW, 6'd0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, "rst_fetch");
    s(4'd1, LW, 6'd0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, "rst_decode");
    s(4'd2, LW, 6'd0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, "rst_memadr");
    s(4'd3, LW, 6'd0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, "rst_memrd_stall");
    s(4'd3, LW, 6'd0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, "rst_in_memrd");
    s(4'd0, LW, 6'd0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, "rst_back_fetch");

    // Let the monitor drain, bounded
    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_multicycle_control
`default_nettype wire
